// File: rtl/matrix_scan_capture_pkg.sv
// Shared definitions for the LED-matrix scan capture block.
// Holds the default grid size, the default row stability threshold, the bit
// positions inside err_o and the pixel indexing helper (pixel (r,c) lives at
// bit r*gs+c of a flattened frame).
package matrix_scan_capture_pkg;

  localparam int unsigned GS     = 8;
  localparam int unsigned STABLE = 4;

  localparam int unsigned ERR_MULTIHOT = 0;
  localparam int unsigned ERR_OVERRUN  = 1;

  // Flattened frame index of pixel (r,c) in a g-wide grid.
  function automatic int unsigned pix_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned g);
    return r * g + c;
  endfunction

endpackage

// File: rtl/matrix_scan_capture_scan_stab.sv
// Scan input stage: registers the row/column scan lines once, counts how many
// consecutive identical samples have been seen and decides when a row is
// stable long enough to commit.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   en_i            capture enable; low clears the stability counter
//   row_val_i       one-hot row select from the scan bus
//   col_val_i       column pixels for the selected row
//   commit_o        one-cycle pulse: row_idx_o/col_o should be written
//   row_idx_o       binary index of the committed row
//   col_o           column data of the committed row
//   multihot_o      one-cycle pulse: a stable sample had more than one row set
module scan_stab
  import matrix_scan_capture_pkg::*;
#(
  parameter int unsigned gs     = GS,
  parameter int unsigned stable = STABLE,
  localparam int unsigned RowW  = (gs > 1) ? $clog2(gs) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic [gs-1:0]   row_val_i,
  input  logic [gs-1:0]   col_val_i,
  output logic            commit_o,
  output logic [RowW-1:0] row_idx_o,
  output logic [gs-1:0]   col_o,
  output logic            multihot_o
);

  localparam int unsigned CntW = $clog2(stable + 1);

  logic [2*gs-1:0] s_q, s_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [gs-1:0]   row;
  logic            hit;
  logic            onehot;
  logic            multi;

  assign row = s_q[2*gs-1:gs];
  assign col_o = s_q[gs-1:0];

  always_comb begin
    s_d   = {row_val_i, col_val_i};
    cnt_d = cnt_q;
    if (!en_i || (s_d != s_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(stable)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Saturation at 'stable' guarantees the threshold value is passed only once
  // per hold, so each held sample commits at most once.
  assign hit    = en_i && (cnt_q == CntW'(stable - 1));
  assign multi  = (row & (row - gs'(1))) != '0;
  assign onehot = (row != '0) && !multi;

  assign commit_o   = hit && onehot;
  assign multihot_o = hit && multi;

  always_comb begin
    row_idx_o = '0;
    for (int unsigned i = 0; i < gs; i++) begin
      if (row[i]) row_idx_o = RowW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/matrix_scan_capture.sv
// Reconstructs a gs x gs frame from the LED-matrix row/column scan lines and
// delivers each completed frame on a valid/ready handshake.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   en_i            capture enable; low abandons the frame being assembled
//   row_val_i       one-hot active row (all-zero = blanking)
//   col_val_i       column pixels of the active row
//   frame_ready_i   consumer accepts the published frame
//   matrix_o        published frame, pixel (r,c) at bit r*gs+c
//   frame_valid_o   matrix_o holds an unconsumed frame
//   changed_o       published frame differs from the previous one
//   err_o           sticky errors: [0] multi-hot row, [1] frame overrun
module matrix_scan_capture
  import matrix_scan_capture_pkg::*;
#(
  parameter int unsigned gs     = GS,
  parameter int unsigned stable = STABLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [gs-1:0]    row_val_i,
  input  logic [gs-1:0]    col_val_i,
  input  logic             frame_ready_i,
  output logic [gs*gs-1:0] matrix_o,
  output logic             frame_valid_o,
  output logic             changed_o,
  output logic [1:0]       err_o
);

  localparam int unsigned RowW = (gs > 1) ? $clog2(gs) : 1;

  logic            commit;
  logic [RowW-1:0] row_idx;
  logic [gs-1:0]   col;
  logic            multihot;

  logic [gs*gs-1:0] buf_q, buf_d;
  logic [gs-1:0]    seen_q, seen_d;
  logic [gs*gs-1:0] matrix_q, matrix_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;
  logic [1:0]       err_q, err_d;

  scan_stab #(
    .gs     (gs),
    .stable (stable)
  ) u_scan_stab (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .row_val_i  (row_val_i),
    .col_val_i  (col_val_i),
    .commit_o   (commit),
    .row_idx_o  (row_idx),
    .col_o      (col),
    .multihot_o (multihot)
  );

  always_comb begin
    buf_d     = buf_q;
    seen_d    = seen_q;
    matrix_d  = matrix_q;
    valid_d   = valid_q;
    changed_d = changed_q;
    err_d     = err_q;

    if (valid_q && frame_ready_i) valid_d = 1'b0;

    // Publish the finished frame; a slot freed on this same edge counts as free.
    if (&seen_q) begin
      seen_d = '0;
      if (!valid_q || frame_ready_i) begin
        matrix_d  = buf_q;
        valid_d   = 1'b1;
        changed_d = (buf_q != matrix_q);
      end else begin
        err_d[ERR_OVERRUN] = 1'b1;
      end
    end

    // Commit after the publish clear so a row landing on the publish edge
    // starts the next frame.
    if (!en_i) begin
      seen_d = '0;
    end else if (commit) begin
      for (int unsigned r = 0; r < gs; r++) begin
        if (row_idx == RowW'(r)) buf_d[pix_idx(r, 0, gs) +: gs] = col;
      end
      seen_d[row_idx] = 1'b1;
    end

    if (multihot) err_d[ERR_MULTIHOT] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q     <= '0;
      seen_q    <= '0;
      matrix_q  <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      err_q     <= '0;
    end else begin
      buf_q     <= buf_d;
      seen_q    <= seen_d;
      matrix_q  <= matrix_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      err_q     <= err_d;
    end
  end

  assign matrix_o      = matrix_q;
  assign frame_valid_o = valid_q;
  assign changed_o     = changed_q;
  assign err_o         = err_q;

endmodule
